// File: rtl/deck_dealer_if.sv
// ============================================================================
// deck_dealer_if : controller <-> card dealer handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface deck_dealer_if;
  logic [5:0] seed;
  logic       shuffle_req;
  logic       draw_req;
  logic       busy;
  logic       shuffle_done;
  logic       draw_ack;
  logic [5:0] card;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       deck_empty;

  modport master (
    output seed, shuffle_req, draw_req,
    input  busy, shuffle_done, draw_ack, card, card_rank, card_value, cards_left, deck_empty
  );

  modport slave (
    input  seed, shuffle_req, draw_req,
    output busy, shuffle_done, draw_ack, card, card_rank, card_value, cards_left, deck_empty
  );
endinterface

`default_nettype wire

// File: rtl/deck_dealer.sv
// ============================================================================
// deck_dealer : LFSR-driven Fisher-Yates shuffled deck, one card per draw
// Rev 1.0
// ============================================================================
`default_nettype none

module deck_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int LFSR_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  deck_dealer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INIT    = 2'd1,
    S_SHUFFLE = 2'd2,
    S_READY   = 2'd3
  } state_t;

  localparam logic [5:0]        C_LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0]        C_FULL = 6'(DECK_SIZE);
  localparam logic [LFSR_W-1:0] C_TAPS = LFSR_W'('hB400);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [5:0]        deck_q [DECK_SIZE];
  logic [5:0]        deck_d [DECK_SIZE];
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        top_q, top_d;
  logic [5:0]        cards_left_q, cards_left_d;
  logic              deck_empty_q, deck_empty_d;
  logic              busy_q, busy_d;
  logic              shuffle_done_q, shuffle_done_d;
  logic              draw_ack_q, draw_ack_d;
  logic [5:0]        card_q, card_d;
  logic [3:0]        card_rank_q, card_rank_d;
  logic [3:0]        card_value_q, card_value_d;

  logic [LFSR_W-1:0] lfsr_next;
  logic [5:0]        cand;
  logic [5:0]        deal_id;
  logic [5:0]        deal_rem;
  logic [3:0]        deal_rank;
  logic [3:0]        deal_value;

  // Rank from id without a divider: strip whole suits of 13 by comparison.
  always_comb begin
    deal_id = deck_q[top_q];
    if (deal_id >= 6'd39)      deal_rem = deal_id - 6'd39;
    else if (deal_id >= 6'd26) deal_rem = deal_id - 6'd26;
    else if (deal_id >= 6'd13) deal_rem = deal_id - 6'd13;
    else                       deal_rem = deal_id;
    deal_rank  = 4'(deal_rem) + 4'd1;
    deal_value = (deal_rank >= 4'd10) ? 4'd10 : deal_rank;
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    deck_d         = deck_q;
    idx_d          = idx_q;
    top_d          = top_q;
    cards_left_d   = cards_left_q;
    deck_empty_d   = deck_empty_q;
    busy_d         = busy_q;
    shuffle_done_d = 1'b0;
    draw_ack_d     = 1'b0;
    card_d         = card_q;
    card_rank_d    = card_rank_q;
    card_value_d   = card_value_q;

    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ C_TAPS) : (lfsr_q >> 1);
    cand      = lfsr_q[5:0];

    case (state_q)
      S_IDLE: begin
        if (bus.shuffle_req) begin
          state_d      = S_INIT;
          lfsr_d       = LFSR_W'({bus.seed, 10'h2A5});
          busy_d       = 1'b1;
          cards_left_d = 6'd0;
          deck_empty_d = 1'b1;
        end
      end

      S_INIT: begin
        for (int k = 0; k < DECK_SIZE; k++) begin
          deck_d[k] = 6'(k);
        end
        idx_d   = C_LAST;
        state_d = S_SHUFFLE;
      end

      S_SHUFFLE: begin
        lfsr_d = lfsr_next;
        // Out-of-range candidates are rejected to keep the permutation uniform.
        if (cand <= idx_q) begin
          deck_d[idx_q] = deck_q[cand];
          deck_d[cand]  = deck_q[idx_q];
          if (idx_q == 6'd1) begin
            state_d        = S_READY;
            shuffle_done_d = 1'b1;
            top_d          = 6'd0;
            cards_left_d   = C_FULL;
            deck_empty_d   = 1'b0;
            busy_d         = 1'b0;
          end else begin
            idx_d = idx_q - 6'd1;
          end
        end
      end

      S_READY: begin
        if (bus.shuffle_req) begin
          state_d      = S_INIT;
          lfsr_d       = LFSR_W'({bus.seed, 10'h2A5});
          busy_d       = 1'b1;
          cards_left_d = 6'd0;
          deck_empty_d = 1'b1;
        end else if (bus.draw_req && !draw_ack_q && (cards_left_q != 6'd0)) begin
          draw_ack_d   = 1'b1;
          card_d       = deal_id;
          card_rank_d  = deal_rank;
          card_value_d = deal_value;
          top_d        = top_q + 6'd1;
          cards_left_d = cards_left_q - 6'd1;
          deck_empty_d = (cards_left_q == 6'd1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_W'(1);
      for (int k = 0; k < DECK_SIZE; k++) begin
        deck_q[k] <= 6'd0;
      end
      idx_q          <= 6'd0;
      top_q          <= 6'd0;
      cards_left_q   <= 6'd0;
      deck_empty_q   <= 1'b1;
      busy_q         <= 1'b0;
      shuffle_done_q <= 1'b0;
      draw_ack_q     <= 1'b0;
      card_q         <= 6'd0;
      card_rank_q    <= 4'd0;
      card_value_q   <= 4'd0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      deck_q         <= deck_d;
      idx_q          <= idx_d;
      top_q          <= top_d;
      cards_left_q   <= cards_left_d;
      deck_empty_q   <= deck_empty_d;
      busy_q         <= busy_d;
      shuffle_done_q <= shuffle_done_d;
      draw_ack_q     <= draw_ack_d;
      card_q         <= card_d;
      card_rank_q    <= card_rank_d;
      card_value_q   <= card_value_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.shuffle_done = shuffle_done_q;
  assign bus.draw_ack     = draw_ack_q;
  assign bus.card         = card_q;
  assign bus.card_rank    = card_rank_q;
  assign bus.card_value   = card_value_q;
  assign bus.cards_left   = cards_left_q;
  assign bus.deck_empty   = deck_empty_q;

endmodule

`default_nettype wire

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer: reference shuffle model, decode table, handshake corners.
`default_nettype none

module tb_deck_dealer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deck_dealer_if dif ();

  deck_dealer #(.DECK_SIZE(52), .LFSR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  typedef struct {
    logic [5:0] id;
    logic [3:0] rank;
    logic [3:0] value;
  } dec_vec_t;

  dec_vec_t   dec_tab [10];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] model_deck [52];
  int         model_steps;
  logic [5:0] dealt [52];
  logic [5:0] seq_a [52];
  logic [5:0] seq_b [52];
  logic [5:0] seq_0 [52];
  logic [3:0] rank_of [52];
  logic [3:0] val_of [52];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Reference Fisher-Yates driven by the Galois LFSR, also yielding the step count.
  task automatic model_shuffle(input logic [5:0] s);
    logic [15:0] lf;
    logic [5:0]  t;
    int          i;
    int          j;
    for (int k = 0; k < 52; k++) model_deck[k] = 6'(k);
    lf          = {s, 10'h2A5};
    i           = 51;
    model_steps = 0;
    while (model_steps < 100000) begin
      j = int'(lf[5:0]);
      model_steps++;
      if (j <= i) begin
        t             = model_deck[i];
        model_deck[i] = model_deck[j];
        model_deck[j] = t;
        if (i == 1) break;
        i--;
      end
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
  endtask

  task automatic do_shuffle(input logic [5:0] s, input string tag);
    int n;
    int acks;
    model_shuffle(s);
    dif.seed        = s;
    dif.shuffle_req = 1'b1;
    dif.draw_req    = 1'b1;
    step_clk();
    check({tag, " busy_after_req"}, dif.busy, 1);
    check({tag, " no_ack_on_req"}, dif.draw_ack, 0);
    dif.shuffle_req = 1'b0;
    n    = 0;
    acks = 0;
    while (!dif.shuffle_done && n < 20000) begin
      step_clk();
      n++;
      if (dif.draw_ack) acks++;
    end
    dif.draw_req = 1'b0;
    check({tag, " shuffle_latency"}, n, model_steps + 1);
    check({tag, " acks_while_busy"}, acks, 0);
    check({tag, " busy_at_done"}, dif.busy, 0);
    check({tag, " cards_left_at_done"}, dif.cards_left, 52);
    check({tag, " empty_at_done"}, dif.deck_empty, 0);
    step_clk();
    check({tag, " done_is_pulse"}, dif.shuffle_done, 0);
  endtask

  task automatic deal_all(input string tag);
    int seen [52];
    int n;
    int r;
    for (int k = 0; k < 52; k++) seen[k] = 0;
    dif.draw_req = 1'b1;
    for (int c = 0; c < 52; c++) begin
      step_clk();
      check({tag, " ack"}, dif.draw_ack, 1);
      dealt[c] = dif.card;
      check({tag, " card_vs_model"}, dif.card, model_deck[c]);
      check({tag, " cards_left"}, dif.cards_left, 51 - c);
      check({tag, " deck_empty"}, dif.deck_empty, (c == 51) ? 1 : 0);
      r = (int'(dif.card) % 13) + 1;
      check({tag, " rank"}, dif.card_rank, r);
      check({tag, " value"}, dif.card_value, (r >= 10) ? 10 : r);
      if (dif.card < 6'd52) begin
        seen[dif.card]++;
        rank_of[dif.card] = dif.card_rank;
        val_of[dif.card]  = dif.card_value;
      end
      step_clk();
      check({tag, " ack_gap"}, dif.draw_ack, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step_clk();
      check({tag, " empty_no_ack"}, dif.draw_ack, 0);
      check({tag, " empty_cards_left"}, dif.cards_left, 0);
      check({tag, " empty_flag"}, dif.deck_empty, 1);
    end
    dif.draw_req = 1'b0;
    n = 0;
    for (int k = 0; k < 52; k++) if (seen[k] == 1) n++;
    check({tag, " permutation"}, n, 52);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndiff;

    dec_tab[0] = '{6'd0,  4'd1,  4'd1};
    dec_tab[1] = '{6'd9,  4'd10, 4'd10};
    dec_tab[2] = '{6'd12, 4'd13, 4'd10};
    dec_tab[3] = '{6'd13, 4'd1,  4'd1};
    dec_tab[4] = '{6'd21, 4'd9,  4'd9};
    dec_tab[5] = '{6'd26, 4'd1,  4'd1};
    dec_tab[6] = '{6'd38, 4'd13, 4'd10};
    dec_tab[7] = '{6'd39, 4'd1,  4'd1};
    dec_tab[8] = '{6'd47, 4'd9,  4'd9};
    dec_tab[9] = '{6'd51, 4'd13, 4'd10};

    dif.seed        = 6'd0;
    dif.shuffle_req = 1'b0;
    dif.draw_req    = 1'b0;
    rst             = 1'b0;
    repeat (3) step_clk();
    check("rst busy", dif.busy, 0);
    check("rst deck_empty", dif.deck_empty, 1);
    check("rst cards_left", dif.cards_left, 0);
    check("rst draw_ack", dif.draw_ack, 0);
    check("rst card", dif.card, 0);
    check("rst shuffle_done", dif.shuffle_done, 0);
    check("rst card_rank", dif.card_rank, 0);
    check("rst card_value", dif.card_value, 0);
    rst = 1'b1;

    dif.draw_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      check("idle draw_ack", dif.draw_ack, 0);
      check("idle cards_left", dif.cards_left, 0);
      check("idle busy", dif.busy, 0);
    end
    dif.draw_req = 1'b0;

    do_shuffle(6'b001010, "s10a");
    deal_all("s10a");
    seq_a = dealt;

    for (int v = 0; v < 10; v++) begin
      check($sformatf("decode rank id%0d", dec_tab[v].id), rank_of[dec_tab[v].id], dec_tab[v].rank);
      check($sformatf("decode value id%0d", dec_tab[v].id), val_of[dec_tab[v].id], dec_tab[v].value);
    end

    do_shuffle(6'b001010, "s10b");
    deal_all("s10b");
    seq_b = dealt;
    ndiff = 0;
    for (int k = 0; k < 52; k++) if (seq_a[k] != seq_b[k]) ndiff++;
    check("determinism differing_positions", ndiff, 0);

    do_shuffle(6'd0, "seed0");
    deal_all("seed0");
    seq_0 = dealt;

    // Two cards out of the seed-1 deck, then reshuffle from a part-dealt READY.
    do_shuffle(6'd1, "seed1pre");
    dif.draw_req = 1'b1;
    step_clk();
    check("partial ack0", dif.draw_ack, 1);
    check("partial card0", dif.card, model_deck[0]);
    step_clk();
    check("partial gap", dif.draw_ack, 0);
    step_clk();
    check("partial ack1", dif.draw_ack, 1);
    check("partial card1", dif.card, model_deck[1]);
    check("partial cards_left", dif.cards_left, 50);
    dif.draw_req = 1'b0;
    step_clk();
    do_shuffle(6'd1, "seed1");
    deal_all("seed1");
    ndiff = 0;
    for (int k = 0; k < 52; k++) if (seq_0[k] != dealt[k]) ndiff++;
    check("seed0_vs_seed1 differ", (ndiff > 0) ? 1 : 0, 1);

    dif.seed        = 6'b001010;
    dif.shuffle_req = 1'b1;
    step_clk();
    dif.shuffle_req = 1'b0;
    repeat (10) step_clk();
    check("midshuffle busy_before_rst", dif.busy, 1);
    rst = 1'b0;
    step_clk();
    check("midrst busy", dif.busy, 0);
    check("midrst shuffle_done", dif.shuffle_done, 0);
    check("midrst deck_empty", dif.deck_empty, 1);
    check("midrst cards_left", dif.cards_left, 0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_clk();
      check("postrst idle_busy", dif.busy, 0);
      check("postrst no_done", dif.shuffle_done, 0);
    end
    do_shuffle(6'b001010, "postrst");
    deal_all("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
